// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, datapath select codes,
// FSM state encodings and the bundled control word.
package multi_cycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    // An instruction retires on the last cycle of its final state.
    function automatic logic is_retire(input state_t s, input logic mem_ready);
        case (s)
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: return 1'b1;
            S_MEM_WRITE:                                return mem_ready;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller side uses the master modport.
interface multi_cycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       Op_i;
    logic             mem_ready_i;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic             MemtoReg_o;
    logic             RegDst_o;
    logic             RegWrite_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic             ZeroExt_o;
    logic [1:0]       ALUOp_o;
    logic [1:0]       PCSource_o;
    logic             illegal_o;
    logic [CNT_W-1:0] retired_o;
    logic [3:0]       state_o;

    modport master (
        input  Op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ZeroExt_o,
               ALUOp_o, PCSource_o, illegal_o, retired_o, state_o
    );

    modport slave (
        output Op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ZeroExt_o,
               ALUOp_o, PCSource_o, illegal_o, retired_o, state_o
    );
endinterface

// File: rtl/multi_cycle_out_decode.sv
// Moore output decode: state (plus latched opcode in I_EXEC and mem_ready in FETCH) to control word.
module multi_cycle_out_decode
    import multi_cycle_control_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        // Reset forces every control output low, even mid-instruction.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.iord      = 1'b0;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_BRANCH;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    if (op_q == OP_ORI) begin
                        ctrl.alu_op   = ALUOP_OR;
                        ctrl.zero_ext = 1'b1;
                    end else begin
                        ctrl.alu_op   = ALUOP_ADD;
                        ctrl.zero_ext = 1'b0;
                    end
                end
                S_I_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b0;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ILLEGAL: begin
                    ctrl.illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main controller: state register, opcode latch, next-state logic and
// retired-instruction counter; output decode lives in multi_cycle_out_decode.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multi_cycle_control_if.master bus
);

    state_t           state;
    state_t           next_state;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retired;
    logic             retire;
    ctrl_t            ctrl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Opcode is captured only in DECODE so later IR changes cannot disturb the instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            retired <= '0;
        end else begin
            if (state == S_DECODE) begin
                op_q <= bus.Op_i;
            end
            if (retire) begin
                retired <= retired + 1'b1;
            end
        end
    end

    assign retire = is_retire(state, bus.mem_ready_i);

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = bus.mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op_i)
                    OP_RTYPE:       next_state = S_R_EXEC;
                    OP_ADDI, OP_ORI: next_state = S_I_EXEC;
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_BEQ:         next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = bus.mem_ready_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: next_state = bus.mem_ready_i ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    next_state = S_R_WB;
            S_I_EXEC:    next_state = S_I_WB;
            default:     next_state = S_FETCH;
        endcase
    end

    multi_cycle_out_decode u_out_decode (
        .rst       (rst_i),
        .state     (state),
        .op_q      (op_q),
        .mem_ready (bus.mem_ready_i),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite_o     = ctrl.pc_write;
    assign bus.PCWriteCond_o = ctrl.pc_write_cond;
    assign bus.IorD_o        = ctrl.iord;
    assign bus.MemRead_o     = ctrl.mem_read;
    assign bus.MemWrite_o    = ctrl.mem_write;
    assign bus.IRWrite_o     = ctrl.ir_write;
    assign bus.MemtoReg_o    = ctrl.mem_to_reg;
    assign bus.RegDst_o      = ctrl.reg_dst;
    assign bus.RegWrite_o    = ctrl.reg_write;
    assign bus.ALUSrcA_o     = ctrl.alu_src_a;
    assign bus.ALUSrcB_o     = ctrl.alu_src_b;
    assign bus.ZeroExt_o     = ctrl.zero_ext;
    assign bus.ALUOp_o       = ctrl.alu_op;
    assign bus.PCSource_o    = ctrl.pc_source;
    assign bus.illegal_o     = ctrl.illegal;
    assign bus.retired_o     = retired;
    assign bus.state_o       = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle state and control-word checks per instruction class.
module tb_multi_cycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
                           S_I_EXEC = 4'd8, S_I_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                           S_ILLEGAL = 4'd12;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ZeroExt,ALUOp,PCSource,illegal}
    localparam logic [17:0] E_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_0_00_00_0;
    localparam logic [17:0] E_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_0_00_00_0;
    localparam logic [17:0] E_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_0;
    localparam logic [17:0] E_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [17:0] E_MEM_READ   = 18'b0_0_1_1_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [17:0] E_MEM_WB     = 18'b0_0_0_0_0_0_1_0_1_0_00_0_00_00_0;
    localparam logic [17:0] E_MEM_WRITE  = 18'b0_0_1_0_1_0_0_0_0_0_00_0_00_00_0;
    localparam logic [17:0] E_R_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_0_11_00_0;
    localparam logic [17:0] E_R_WB       = 18'b0_0_0_0_0_0_0_1_1_0_00_0_00_00_0;
    localparam logic [17:0] E_ADDI_EXEC  = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [17:0] E_ORI_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_10_1_10_00_0;
    localparam logic [17:0] E_I_WB       = 18'b0_0_0_0_0_0_0_0_1_0_00_0_00_00_0;
    localparam logic [17:0] E_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_0_01_01_0;
    localparam logic [17:0] E_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_0_00_10_0;
    localparam logic [17:0] E_ILLEGAL    = 18'b0_0_0_0_0_0_0_0_0_0_00_0_00_00_1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [3:0]  exp_ret = '0;
    logic [17:0] ctl;

    always #5 clk = ~clk;

    multi_cycle_control_if #(.CNT_W(4)) bus ();

    multi_cycle_control #(.CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    assign ctl = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o, bus.MemWrite_o,
                  bus.IRWrite_o, bus.MemtoReg_o, bus.RegDst_o, bus.RegWrite_o, bus.ALUSrcA_o,
                  bus.ALUSrcB_o, bus.ZeroExt_o, bus.ALUOp_o, bus.PCSource_o, bus.illegal_o};

    task automatic test_reset();
        rst = 1'b1; bus.Op_i = 6'h23; bus.mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ctl !== 18'd0) begin bad++; $display("FAIL reset_ctl: got %b want 0", ctl); end
        rst = 1'b0; bus.mem_ready_i = 1'b0;
        #1;
        total++; if (bus.state_o !== S_FETCH) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state_o, S_FETCH); end
        total++; if (bus.retired_o !== 4'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", bus.retired_o); end
        total++; if (ctl !== E_FETCH_WAIT) begin bad++; $display("FAIL reset_fetch_ctl: got %b want %b", ctl, E_FETCH_WAIT); end
    endtask

    task automatic test_add();
        logic [3:0]  st [5] = '{S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_FETCH};
        logic [17:0] ex [5] = '{E_FETCH_RDY, E_DECODE, E_R_EXEC, E_R_WB, E_FETCH_WAIT};
        logic        rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.Op_i = (st[i] == S_DECODE) ? 6'h00 : 6'h3F;
            bus.mem_ready_i = rd[i];
            #1;
            total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL add_ctl[%0d]: got %b want %b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        exp_ret++;
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL add_retired: got %0d want %0d", bus.retired_o, exp_ret); end
    endtask

    task automatic test_lw();
        logic [3:0]  st [8] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB, S_FETCH};
        logic [17:0] ex [8] = '{E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_READ, E_MEM_READ, E_MEM_WB, E_FETCH_WAIT};
        logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.Op_i = (st[i] == S_DECODE) ? 6'h23 : 6'h2B;
            bus.mem_ready_i = rd[i];
            #1;
            total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL lw_ctl[%0d]: got %b want %b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        exp_ret++;
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL lw_retired: got %0d want %0d", bus.retired_o, exp_ret); end
    endtask

    task automatic test_sw();
        logic [3:0]  st [7] = '{S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WRITE, S_MEM_WRITE, S_FETCH};
        logic [17:0] ex [7] = '{E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEM_ADDR, E_MEM_WRITE, E_MEM_WRITE, E_FETCH_WAIT};
        logic        rd [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            bus.Op_i = (st[i] == S_DECODE) ? 6'h2B : 6'h23;
            bus.mem_ready_i = rd[i];
            #1;
            total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL sw_ctl[%0d]: got %b want %b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        exp_ret++;
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL sw_retired: got %0d want %0d", bus.retired_o, exp_ret); end
    endtask

    task automatic test_itype();
        logic [5:0]  ops [2] = '{6'h08, 6'h0D};
        logic [3:0]  st [5] = '{S_FETCH, S_DECODE, S_I_EXEC, S_I_WB, S_FETCH};
        logic [17:0] ex [2][5] = '{'{E_FETCH_RDY, E_DECODE, E_ADDI_EXEC, E_I_WB, E_FETCH_WAIT},
                                   '{E_FETCH_RDY, E_DECODE, E_ORI_EXEC,  E_I_WB, E_FETCH_WAIT}};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                // Opcode toggles to the other I-type outside DECODE; I_EXEC must follow the latched one.
                bus.Op_i = (st[i] == S_DECODE) ? ops[k] : ops[1-k];
                bus.mem_ready_i = (i == 0);
                #1;
                total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL itype%0d_state[%0d]: got %0d want %0d", k, i, bus.state_o, st[i]); end
                total++; if (ctl !== ex[k][i]) begin bad++; $display("FAIL itype%0d_ctl[%0d]: got %b want %b", k, i, ctl, ex[k][i]); end
                @(posedge clk); #1;
            end
            exp_ret++;
            total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL itype%0d_retired: got %0d want %0d", k, bus.retired_o, exp_ret); end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops [2] = '{6'h04, 6'h02};
        logic [3:0]  st [2][4] = '{'{S_FETCH, S_DECODE, S_BRANCH, S_FETCH},
                                   '{S_FETCH, S_DECODE, S_JUMP,   S_FETCH}};
        logic [17:0] ex [2][4] = '{'{E_FETCH_RDY, E_DECODE, E_BRANCH, E_FETCH_WAIT},
                                   '{E_FETCH_RDY, E_DECODE, E_JUMP,   E_FETCH_WAIT}};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                bus.Op_i = (i == 1) ? ops[k] : 6'h00;
                bus.mem_ready_i = (i == 0);
                #1;
                total++; if (bus.state_o !== st[k][i]) begin bad++; $display("FAIL bj%0d_state[%0d]: got %0d want %0d", k, i, bus.state_o, st[k][i]); end
                total++; if (ctl !== ex[k][i]) begin bad++; $display("FAIL bj%0d_ctl[%0d]: got %b want %b", k, i, ctl, ex[k][i]); end
                @(posedge clk); #1;
            end
            exp_ret++;
            total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL bj%0d_retired: got %0d want %0d", k, bus.retired_o, exp_ret); end
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [4] = '{S_FETCH, S_DECODE, S_ILLEGAL, S_FETCH};
        logic [17:0] ex [4] = '{E_FETCH_RDY, E_DECODE, E_ILLEGAL, E_FETCH_WAIT};
        for (int i = 0; i < 4; i++) begin
            bus.Op_i = (i == 1) ? 6'h3F : 6'h00;
            bus.mem_ready_i = (i == 0);
            #1;
            total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
            total++; if (ctl !== ex[i]) begin bad++; $display("FAIL illegal_ctl[%0d]: got %b want %b", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL illegal_retired: got %0d want %0d", bus.retired_o, exp_ret); end
    endtask

    task automatic test_wrap();
        // 16 jumps on a 4-bit counter must pass through 15 -> 0.
        for (int n = 0; n < 16; n++) begin
            bus.mem_ready_i = 1'b1; bus.Op_i = 6'h3F;
            @(posedge clk); #1;
            bus.Op_i = 6'h02;
            @(posedge clk); #1;
            total++; if (bus.state_o !== S_JUMP) begin bad++; $display("FAIL wrap_state[%0d]: got %0d want %0d", n, bus.state_o, S_JUMP); end
            @(posedge clk); #1;
            exp_ret++;
            total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL wrap_retired[%0d]: got %0d want %0d", n, bus.retired_o, exp_ret); end
        end
    endtask

    task automatic test_reset_mid_instr();
        logic [3:0] st [4] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ};
        for (int i = 0; i < 4; i++) begin
            bus.Op_i = 6'h23;
            bus.mem_ready_i = (i < 3);
            #1;
            total++; if (bus.state_o !== st[i]) begin bad++; $display("FAIL rstmid_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1; bus.mem_ready_i = 1'b1;
        #1;
        total++; if (ctl !== 18'd0) begin bad++; $display("FAIL rstmid_ctl: got %b want 0", ctl); end
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ready_i = 1'b0;
        exp_ret = '0;
        #1;
        total++; if (bus.state_o !== S_FETCH) begin bad++; $display("FAIL rstmid_state_after: got %0d want %0d", bus.state_o, S_FETCH); end
        total++; if (bus.retired_o !== exp_ret) begin bad++; $display("FAIL rstmid_retired: got %0d want 0", bus.retired_o); end
    endtask

    initial begin
        bus.Op_i = '0;
        bus.mem_ready_i = 1'b0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_itype();
        test_branch_jump();
        test_illegal();
        test_wrap();
        test_reset_mid_instr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
